// File: rtl/parameters_pkg.sv
// Shared constants, FSM state type and prescale helper for the UART receiver.
package parameters_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    function automatic logic is_supported_prescale(input int unsigned p);
        return (p == 8) || (p == 16) || (p == 32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority vote around the middle of each bit period.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      sampled_bit
);

    logic [PRESCALE_WIDTH-1:0] w_mid;
    logic [2:0]                r_samples;

    assign w_mid = Prescale >> 1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_samples <= '0;
        end else begin
            if (edge_cnt == w_mid - PRESCALE_WIDTH'(1)) r_samples[0] <= RX_IN;
            if (edge_cnt == w_mid)                      r_samples[1] <= RX_IN;
            if (edge_cnt == w_mid + PRESCALE_WIDTH'(1)) r_samples[2] <= RX_IN;
        end
    end

    assign sampled_bit = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with registered
// frame-end outcome (data_valid, par_err or stp_err).
module uart_rx #(
    parameter int unsigned DATA_WIDTH     = parameters_pkg::DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    import parameters_pkg::*;

    localparam int unsigned PW = PRESCALE_WIDTH;
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_rx_state_e r_state;
    uart_rx_state_e w_state_nxt;

    logic [PW-1:0]         r_prescale;
    logic [PW-1:0]         r_edge_cnt;
    logic [PW-1:0]         w_prescale_eff;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic                  r_stp_bad;

    logic w_start;
    logic w_eval;
    logic w_last;
    logic w_last_bit;
    logic w_sampled;

    assign w_prescale_eff = is_supported_prescale(32'(Prescale)) ? Prescale : PW'(8);
    assign w_start        = (r_state == IDLE) && !RX_IN;
    assign w_eval         = (r_edge_cnt == (r_prescale >> 1) + PW'(2));
    assign w_last         = (r_edge_cnt == r_prescale - PW'(1));
    assign w_last_bit     = (r_bit_cnt == LAST_BIT);

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .edge_cnt   (r_edge_cnt),
        .Prescale   (r_prescale),
        .sampled_bit(w_sampled)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = START;
            end
            START: begin
                // A start bit that votes high was a glitch.
                if (w_eval && w_sampled)  w_state_nxt = IDLE;
                else if (w_last)          w_state_nxt = DATA;
            end
            DATA: begin
                if (w_last && w_last_bit) w_state_nxt = r_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (w_last) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prescale <= PW'(8);
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            // Start-detect cycle is edge 0, so the counter leaves IDLE at 1.
            if ((w_state_nxt == IDLE) || w_last) r_edge_cnt <= '0;
            else                                 r_edge_cnt <= r_edge_cnt + PW'(1);

            if (w_start) begin
                r_prescale <= w_prescale_eff;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_par_bad  <= 1'b0;
                r_stp_bad  <= 1'b0;
                r_bit_cnt  <= '0;
            end

            case (r_state)
                DATA: begin
                    if (w_eval) r_shift <= {w_sampled, r_shift[DATA_WIDTH-1:1]};
                    if (w_last) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BW'(1);
                end
                PARITY: begin
                    if (w_eval) r_par_bad <= (w_sampled != ((^r_shift) ^ r_par_typ));
                end
                STOP: begin
                    if (w_eval) r_stp_bad <= ~w_sampled;
                    if (w_last) begin
                        if (!r_par_bad && !r_stp_bad) begin
                            data_valid <= 1'b1;
                            P_DATA     <= r_shift;
                        end else begin
                            par_err <= r_par_bad;
                            stp_err <= r_stp_bad;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed scenarios plus randomized frames.
module tb_uart_rx;

    logic       clk;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK       (clk),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .Prescale  (Prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    typedef struct {
        string       name;
        int unsigned cyc;
        logic [7:0]  data;
        bit          valid;
        bit          par;
        bit          stp;
    } item_t;

    item_t       exp_q[$];
    item_t       mon_it;
    logic [7:0]  last_good = '0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned eff_p(input int unsigned p);
        if (p == 16 || p == 32) return p;
        return 8;
    endfunction

    // Expected outcome comes from the bits put on the wire.
    task automatic send_frame(input string name, input logic [7:0] data, input int unsigned pre,
                              input bit pe, input bit pt, input bit flip_par, input bit stop_v,
                              input bit scramble);
        int unsigned p;
        bit          sent_par;
        bit          exp_par;
        item_t       it;
        p        = eff_p(pre);
        Prescale = 6'(pre);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        sent_par = (^data) ^ pt ^ flip_par;
        exp_par  = (($countones(data) % 2) == 1) ^ pt;
        it.name  = name;
        it.data  = data;
        it.par   = pe && (sent_par != exp_par);
        it.stp   = !stop_v;
        it.valid = !it.par && !it.stp;
        it.cyc   = cyc + p * (10 + (pe ? 1 : 0));
        exp_q.push_back(it);
        RX_IN = 1'b0;
        tick();
        if (scramble) begin
            Prescale = 6'($urandom_range(0, 63));
            PAR_EN   = 1'($urandom_range(0, 1));
            PAR_TYP  = 1'($urandom_range(0, 1));
        end
        repeat (p - 1) tick();
        for (int b = 0; b < 8; b++) begin
            RX_IN = data[b];
            repeat (p) tick();
        end
        if (pe) begin
            RX_IN = sent_par;
            repeat (p) tick();
        end
        RX_IN = stop_v;
        repeat (p) tick();
        RX_IN = 1'b1;
    endtask

    always @(negedge clk) begin
        if (RST) begin
            last_good = '0;
        end else if (data_valid || par_err || stp_err) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: valid=%0b par_err=%0b stp_err=%0b at cycle %0d, none required",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                mon_it = exp_q.pop_front();
                check({mon_it.name, "/cycle"}, cyc, mon_it.cyc);
                check({mon_it.name, "/data_valid"}, 32'(data_valid), 32'(mon_it.valid));
                check({mon_it.name, "/par_err"}, 32'(par_err), 32'(mon_it.par));
                check({mon_it.name, "/stp_err"}, 32'(stp_err), 32'(mon_it.stp));
                if (mon_it.valid) last_good = mon_it.data;
                check({mon_it.name, "/P_DATA"}, 32'(P_DATA), 32'(last_good));
            end
        end
    end

    initial begin : stim
        logic [7:0] d;
        int unsigned sel;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/P_DATA", 32'(P_DATA), 32'h0);
        check("reset/data_valid", 32'(data_valid), 32'h0);
        check("reset/par_err", 32'(par_err), 32'h0);
        check("reset/stp_err", 32'(stp_err), 32'h0);
        RST = 1'b0;
        repeat (3) tick();

        send_frame("good_A5_p8", 8'hA5, 8, 1, 0, 0, 1, 0);
        tick();
        send_frame("parerr_3C", 8'h3C, 8, 1, 0, 1, 1, 0);
        tick();
        send_frame("stperr_81_p16", 8'h81, 16, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Two-cycle low glitch must not start a frame.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (2) tick();
        RX_IN = 1'b1;
        repeat (12) tick();
        send_frame("after_glitch_55", 8'h55, 8, 0, 0, 0, 1, 0);
        tick();

        send_frame("b2b_00_p32", 8'h00, 32, 1, 1, 0, 1, 0);
        send_frame("b2b_FF_p32", 8'hFF, 32, 1, 1, 0, 1, 0);
        repeat (2) tick();

        send_frame("break_1", 8'h00, 8, 0, 0, 0, 0, 0);
        send_frame("break_2", 8'h00, 8, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Reset arrives in the middle of data bit 4.
        d        = 8'hA5;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) tick();
        for (int b = 0; b < 4; b++) begin
            RX_IN = d[b];
            repeat (8) tick();
        end
        RX_IN = d[4];
        repeat (3) tick();
        #2 RST = 1'b1;
        #1;
        check("midreset/P_DATA", 32'(P_DATA), 32'h0);
        check("midreset/data_valid", 32'(data_valid), 32'h0);
        check("midreset/par_err", 32'(par_err), 32'h0);
        check("midreset/stp_err", 32'(stp_err), 32'h0);
        RX_IN = 1'b1;
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        repeat (3) tick();
        send_frame("after_reset_12", 8'h12, 8, 0, 0, 0, 1, 0);

        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 4);
            repeat ($urandom_range(0, 3)) tick();
            send_frame($sformatf("rand%0d", n), 8'($urandom_range(0, 255)),
                       (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : (sel == 3) ? 12 : 0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 1);
        end

        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);
        repeat (20) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
